ps2_key_tracker: RTL and testbench

- Consumer stage directly downstream of ps2_keyboard. Drains its byte FIFO through the ready/nextdata_n handshake and decodes the scan-code stream into key state.
- Decodes make, typematic repeat and break (F0-prefixed) events.
- Publishes the held key's scan code, a pressed flag and a press counter, which feed the scan-code-to-ASCII translator and the seven-segment displays.

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_byte_reader.sv | 58 +++++
 rtl/ps2_key_tracker.sv | 104 ++++++++++
 tb/tb_ps2_key_tracker.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: byte-reader handshake states and the scan-code prefix bytes.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StGap
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_byte_reader.sv
// Drains the ps2_keyboard FIFO one byte at a time through the ready/nextdata_n handshake
// and presents each popped byte with a one-cycle valid.
module ps2_byte_reader
  import ps2_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic       nextdata_n_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  ps2_state_e state_q;
  logic [7:0] byte_q;
  logic       nextdata_n_q;
  logic       byte_valid_q;

  // The GAP cycle lets the FIFO read pointer and ready settle before the next sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      byte_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ready_i) begin
            byte_q       <= data_i;
            nextdata_n_q <= 1'b0;
            byte_valid_q <= 1'b1;
            state_q      <= StPop;
          end
        end
        StPop: begin
          nextdata_n_q <= 1'b1;
          byte_valid_q <= 1'b0;
          state_q      <= StGap;
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          nextdata_n_q <= 1'b1;
          byte_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign nextdata_n_o = nextdata_n_q;
  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes the PS/2 scan-code stream (make, typematic repeat, F0 break) into the held key's
// code, a pressed flag, a new-press pulse and counter, plus a sticky overflow flag.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter logic [7:0] BREAK_CODE = PS2_BREAK,
  parameter logic [7:0] EXT_CODE   = PS2_EXT,
  parameter bit         IGNORE_EXT = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  input  logic       kbd_overflow,
  output logic       kbd_nextdata_n,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_event,
  output logic [7:0] press_count,
  output logic       ovf_flag,
  input  logic       ovf_clr
);

  logic [7:0] rd_byte;
  logic       rd_valid;

  ps2_byte_reader u_reader (
    .clk_i        (clock),
    .rst_i        (reset),
    .data_i       (kbd_data),
    .ready_i      (kbd_ready),
    .nextdata_n_o (kbd_nextdata_n),
    .byte_o       (rd_byte),
    .byte_valid_o (rd_valid)
  );

  logic [7:0] key_code_d, key_code_q;
  logic       pressed_d, pressed_q;
  logic       event_d, event_q;
  logic [7:0] count_d, count_q;
  logic       break_d, break_q;
  logic       ovf_d, ovf_q;
  logic       is_break, is_ext;

  assign is_break = (rd_byte == BREAK_CODE);
  assign is_ext   = IGNORE_EXT && (rd_byte == EXT_CODE);

  always_comb begin
    key_code_d = key_code_q;
    pressed_d  = pressed_q;
    event_d    = 1'b0;
    count_d    = count_q;
    break_d    = break_q;
    if (rd_valid && !is_ext) begin
      if (is_break) begin
        break_d = 1'b1;
      end else if (break_q) begin
        // Release of a key other than the tracked one leaves the state untouched.
        break_d = 1'b0;
        if (rd_byte == key_code_q) begin
          pressed_d = 1'b0;
        end
      end else if (!(pressed_q && (rd_byte == key_code_q))) begin
        key_code_d = rd_byte;
        pressed_d  = 1'b1;
        event_d    = 1'b1;
        count_d    = count_q + 8'd1;
      end
    end
    // Set wins over clear.
    if (kbd_overflow) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_code_q <= 8'h00;
      pressed_q  <= 1'b0;
      event_q    <= 1'b0;
      count_q    <= 8'h00;
      break_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      key_code_q <= key_code_d;
      pressed_q  <= pressed_d;
      event_q    <= event_d;
      count_q    <= count_d;
      break_q    <= break_d;
      ovf_q      <= ovf_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_pressed = pressed_q;
  assign key_event   = event_q;
  assign press_count = count_q;
  assign ovf_flag    = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with a behavioural model of the ps2_keyboard FIFO.
module tb_ps2_key_tracker;

  logic       clock;
  logic       reset;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_event;
  logic [7:0] press_count;
  logic       ovf_flag;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int pop_cnt = 0;
  time pop_times[$];
  logic [7:0] fifo[$];

  ps2_key_tracker dut (
    .clock          (clock),
    .reset          (reset),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .key_code       (key_code),
    .key_pressed    (key_pressed),
    .key_event      (key_event),
    .press_count    (press_count),
    .ovf_flag       (ovf_flag),
    .ovf_clr        (ovf_clr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Keyboard FIFO model: pops on a clock edge that sees nextdata_n low.
  always @(posedge clock) begin
    logic [7:0] dummy;
    if (reset) begin
      fifo.delete();
    end else if (!kbd_nextdata_n && fifo.size() > 0) begin
      dummy = fifo.pop_front();
    end
    kbd_ready <= (fifo.size() > 0);
    kbd_data  <= (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  always @(negedge clock) begin
    if (key_event === 1'b1) ev_cnt++;
    if (kbd_nextdata_n === 1'b0) begin
      pop_cnt++;
      pop_times.push_back($time);
    end
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (fifo.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (fifo.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d bytes left, required 0", name, fifo.size());
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (kbd_nextdata_n !== 1'b1) begin
      errors++; $display("FAIL reset nextdata_n: got %b want 1", kbd_nextdata_n);
    end
    checks++;
    if (key_code !== 8'h00) begin
      errors++; $display("FAIL reset key_code: got %h want 00", key_code);
    end
    checks++;
    if (key_pressed !== 1'b0) begin
      errors++; $display("FAIL reset key_pressed: got %b want 0", key_pressed);
    end
    checks++;
    if (key_event !== 1'b0) begin
      errors++; $display("FAIL reset key_event: got %b want 0", key_event);
    end
    checks++;
    if (press_count !== 8'h00) begin
      errors++; $display("FAIL reset press_count: got %h want 00", press_count);
    end
    checks++;
    if (ovf_flag !== 1'b0) begin
      errors++; $display("FAIL reset ovf_flag: got %b want 0", ovf_flag);
    end
  endtask

  task automatic test_press_release();
    int ev0, pop0;
    do_reset();
    ev0 = ev_cnt; pop0 = pop_cnt;
    push(8'h1C);
    drain(50, "press");
    checks++;
    if (key_code !== 8'h1C) begin
      errors++; $display("FAIL press key_code: got %h want 1c", key_code);
    end
    checks++;
    if (key_pressed !== 1'b1) begin
      errors++; $display("FAIL press key_pressed: got %b want 1", key_pressed);
    end
    checks++;
    if (ev_cnt - ev0 !== 1) begin
      errors++; $display("FAIL press events: got %0d want 1", ev_cnt - ev0);
    end
    checks++;
    if (press_count !== 8'd1) begin
      errors++; $display("FAIL press press_count: got %0d want 1", press_count);
    end
    push(8'hF0);
    push(8'h1C);
    drain(50, "release");
    checks++;
    if (key_pressed !== 1'b0) begin
      errors++; $display("FAIL release key_pressed: got %b want 0", key_pressed);
    end
    checks++;
    if (key_code !== 8'h1C) begin
      errors++; $display("FAIL release key_code: got %h want 1c", key_code);
    end
    checks++;
    if (pop_cnt - pop0 !== 3) begin
      errors++; $display("FAIL release pops: got %0d want 3", pop_cnt - pop0);
    end
  endtask

  task automatic test_back_to_back();
    int ev0, pop0, idx0, bad;
    logic [7:0] seq [5];
    seq = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};
    do_reset();
    ev0 = ev_cnt; pop0 = pop_cnt; idx0 = pop_times.size(); bad = 0;
    for (int i = 0; i < 5; i++) push(seq[i]);
    drain(100, "b2b");
    checks++;
    if (press_count !== 8'd1) begin
      errors++; $display("FAIL b2b press_count: got %0d want 1", press_count);
    end
    checks++;
    if (ev_cnt - ev0 !== 1) begin
      errors++; $display("FAIL b2b events: got %0d want 1", ev_cnt - ev0);
    end
    checks++;
    if (pop_cnt - pop0 !== 5) begin
      errors++; $display("FAIL b2b pops: got %0d want 5", pop_cnt - pop0);
    end
    for (int i = idx0 + 1; i < pop_times.size(); i++) begin
      if (pop_times[i] - pop_times[i-1] != 30) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL b2b spacing: got %0d bad gaps want 0", bad);
    end
    checks++;
    if (key_pressed !== 1'b0) begin
      errors++; $display("FAIL b2b key_pressed: got %b want 0", key_pressed);
    end
  endtask

  task automatic test_two_keys();
    do_reset();
    push(8'h1C);
    push(8'h1B);
    drain(50, "two_keys");
    checks++;
    if (key_code !== 8'h1B) begin
      errors++; $display("FAIL two_keys key_code: got %h want 1b", key_code);
    end
    checks++;
    if (press_count !== 8'd2) begin
      errors++; $display("FAIL two_keys press_count: got %0d want 2", press_count);
    end
    push(8'hF0);
    push(8'h1C);
    drain(50, "other_release");
    checks++;
    if (key_pressed !== 1'b1) begin
      errors++; $display("FAIL other_release key_pressed: got %b want 1", key_pressed);
    end
    checks++;
    if (key_code !== 8'h1B) begin
      errors++; $display("FAIL other_release key_code: got %h want 1b", key_code);
    end
  endtask

  task automatic test_ext();
    do_reset();
    push(8'hE0);
    push(8'h75);
    drain(50, "ext_press");
    checks++;
    if (key_code !== 8'h75 || key_pressed !== 1'b1) begin
      errors++;
      $display("FAIL ext_press code/pressed: got %h/%b want 75/1", key_code, key_pressed);
    end
    checks++;
    if (press_count !== 8'd1) begin
      errors++; $display("FAIL ext_press press_count: got %0d want 1", press_count);
    end
    push(8'hF0);
    push(8'hE0);
    push(8'h75);
    drain(50, "ext_release");
    checks++;
    if (key_pressed !== 1'b0 || key_code !== 8'h75) begin
      errors++;
      $display("FAIL ext_release code/pressed: got %h/%b want 75/0", key_code, key_pressed);
    end
  endtask

  task automatic test_wrap();
    int ev0;
    do_reset();
    ev0 = ev_cnt;
    for (int i = 0; i < 256; i++) begin
      push((i % 2 == 0) ? 8'h1C : 8'h1B);
      push(8'hF0);
      push((i % 2 == 0) ? 8'h1C : 8'h1B);
    end
    drain(3000, "wrap");
    checks++;
    if (press_count !== 8'h00) begin
      errors++; $display("FAIL wrap press_count: got %h want 00", press_count);
    end
    checks++;
    if (ev_cnt - ev0 !== 256) begin
      errors++; $display("FAIL wrap events: got %0d want 256", ev_cnt - ev0);
    end
    checks++;
    if (key_code !== 8'h1B || key_pressed !== 1'b0) begin
      errors++;
      $display("FAIL wrap code/pressed: got %h/%b want 1b/0", key_code, key_pressed);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    kbd_overflow = 1'b1;
    @(negedge clock);
    kbd_overflow = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (ovf_flag !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_flag);
    end
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    checks++;
    if (ovf_flag !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", ovf_flag);
    end
    kbd_overflow = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clock);
    kbd_overflow = 1'b0;
    ovf_clr = 1'b0;
    checks++;
    if (ovf_flag !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins: got %b want 1", ovf_flag);
    end
  endtask

  task automatic test_reset_mid_pop();
    int n = 0;
    do_reset();
    push(8'h1C);
    drain(50, "pre_pop");
    kbd_overflow = 1'b1;
    @(negedge clock);
    kbd_overflow = 1'b0;
    push(8'hF0);
    while (kbd_nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (kbd_nextdata_n !== 1'b0) begin
      errors++; $display("FAIL mid_pop reach_pop: nextdata_n %b want 0", kbd_nextdata_n);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (kbd_nextdata_n !== 1'b1) begin
      errors++; $display("FAIL mid_pop nextdata_n: got %b want 1", kbd_nextdata_n);
    end
    checks++;
    if (key_code !== 8'h00 || key_pressed !== 1'b0 || key_event !== 1'b0 ||
        press_count !== 8'h00 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL mid_pop outputs: code %h pressed %b event %b count %h ovf %b want all 0",
               key_code, key_pressed, key_event, press_count, ovf_flag);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    // With the break prefix lost, 1C must register as a fresh press.
    push(8'h1C);
    drain(50, "post_reset");
    checks++;
    if (key_pressed !== 1'b1 || press_count !== 8'd1 || key_code !== 8'h1C) begin
      errors++;
      $display("FAIL post_reset press: code %h pressed %b count %0d want 1c/1/1",
               key_code, key_pressed, press_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    kbd_overflow = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_press_release();
    test_back_to_back();
    test_two_keys();
    test_ext();
    test_wrap();
    test_overflow();
    test_reset_mid_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
